// File: rtl/sram_access_arbiter.sv
// sram_access_arbiter
// Arbitrates the single async SRAM between the audio recorder (writes) and the
// audio player (reads). One access at a time, each held for a fixed number of
// cycles, always separated from the next by at least one idle turnaround cycle.
// Every output comes straight from a register.

module sram_access_arbiter #(
  parameter int ADDR_W    = 20,
  parameter int DATA_W    = 16,
  parameter int WR_CYCLES = 2,
  parameter int RD_CYCLES = 2,
  parameter int PRIO_WR   = 0
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_wr_req,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  output logic              o_wr_ack,
  input  logic              i_rd_req,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic [DATA_W-1:0] o_rd_data,
  output logic              o_rd_valid,
  output logic              o_busy,
  output logic [ADDR_W-1:0] o_sram_addr,
  output logic [DATA_W-1:0] o_sram_dq,
  output logic              o_sram_dq_oe,
  input  logic [DATA_W-1:0] i_sram_dq,
  output logic              o_sram_ce_n,
  output logic              o_sram_oe_n,
  output logic              o_sram_we_n,
  output logic              o_sram_lb_n,
  output logic              o_sram_ub_n
);

  localparam int MAX_CYC = (WR_CYCLES > RD_CYCLES) ? WR_CYCLES : RD_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC) + 1;
  localparam logic [CNT_W-1:0] WR_LAST = CNT_W'(WR_CYCLES - 1);
  localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(RD_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WR   = 2'd1,
    RD   = 2'd2
  } state_t;

  state_t            state, state_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic              last_wr, last_wr_n;
  logic [ADDR_W-1:0] sram_addr_n;
  logic [DATA_W-1:0] sram_dq_n;
  logic [DATA_W-1:0] rd_data_n;
  logic              wr_ack_n, rd_valid_n, busy_n;
  logic              ce_n_n, oe_n_n, we_n_n, lb_n_n, ub_n_n, dq_oe_n;
  logic              grant_wr, grant_rd;

  // Tie-break: a lone request wins outright; on a tie the write wins when
  // writes have priority, otherwise whichever side was not served last.
  always_comb begin
    grant_wr = i_wr_req && (!i_rd_req || (PRIO_WR != 0) || !last_wr);
    grant_rd = i_rd_req && !grant_wr;
  end

  // Next state and next registered outputs; idle strobes are the default so
  // any access ends by releasing the bus.
  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    last_wr_n   = last_wr;
    sram_addr_n = o_sram_addr;
    sram_dq_n   = o_sram_dq;
    rd_data_n   = o_rd_data;
    wr_ack_n    = 1'b0;
    rd_valid_n  = 1'b0;
    ce_n_n      = 1'b1;
    oe_n_n      = 1'b1;
    we_n_n      = 1'b1;
    lb_n_n      = 1'b1;
    ub_n_n      = 1'b1;
    dq_oe_n     = 1'b0;
    case (state)
      IDLE: begin
        if (grant_wr) begin
          state_n     = WR;
          cnt_n       = '0;
          last_wr_n   = 1'b1;
          sram_addr_n = i_wr_addr;
          sram_dq_n   = i_wr_data;
          ce_n_n      = 1'b0;
          we_n_n      = 1'b0;
          lb_n_n      = 1'b0;
          ub_n_n      = 1'b0;
          dq_oe_n     = 1'b1;
          wr_ack_n    = (WR_CYCLES == 1);
        end else if (grant_rd) begin
          state_n     = RD;
          cnt_n       = '0;
          last_wr_n   = 1'b0;
          sram_addr_n = i_rd_addr;
          ce_n_n      = 1'b0;
          oe_n_n      = 1'b0;
          lb_n_n      = 1'b0;
          ub_n_n      = 1'b0;
        end
      end
      WR: begin
        if (cnt == WR_LAST) begin
          state_n = IDLE;
        end else begin
          cnt_n    = cnt + 1'b1;
          ce_n_n   = 1'b0;
          we_n_n   = 1'b0;
          lb_n_n   = 1'b0;
          ub_n_n   = 1'b0;
          dq_oe_n  = 1'b1;
          wr_ack_n = ((cnt + 1'b1) == WR_LAST);
        end
      end
      RD: begin
        if (cnt == RD_LAST) begin
          state_n    = IDLE;
          rd_data_n  = i_sram_dq;
          rd_valid_n = 1'b1;
        end else begin
          cnt_n  = cnt + 1'b1;
          ce_n_n = 1'b0;
          oe_n_n = 1'b0;
          lb_n_n = 1'b0;
          ub_n_n = 1'b0;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
    busy_n = (state_n != IDLE);
  end

  // State and output registers with synchronous active-low reset; a reset
  // during an access simply drops it, so no ack or valid follows.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      last_wr      <= 1'b0;
      o_sram_addr  <= '0;
      o_sram_dq    <= '0;
      o_rd_data    <= '0;
      o_wr_ack     <= 1'b0;
      o_rd_valid   <= 1'b0;
      o_busy       <= 1'b0;
      o_sram_ce_n  <= 1'b1;
      o_sram_oe_n  <= 1'b1;
      o_sram_we_n  <= 1'b1;
      o_sram_lb_n  <= 1'b1;
      o_sram_ub_n  <= 1'b1;
      o_sram_dq_oe <= 1'b0;
    end else begin
      state        <= state_n;
      cnt          <= cnt_n;
      last_wr      <= last_wr_n;
      o_sram_addr  <= sram_addr_n;
      o_sram_dq    <= sram_dq_n;
      o_rd_data    <= rd_data_n;
      o_wr_ack     <= wr_ack_n;
      o_rd_valid   <= rd_valid_n;
      o_busy       <= busy_n;
      o_sram_ce_n  <= ce_n_n;
      o_sram_oe_n  <= oe_n_n;
      o_sram_we_n  <= we_n_n;
      o_sram_lb_n  <= lb_n_n;
      o_sram_ub_n  <= ub_n_n;
      o_sram_dq_oe <= dq_oe_n;
    end
  end

endmodule

// File: tb/tb_sram_access_arbiter.sv
// tb_sram_access_arbiter
// Two arbiters: "a" with default timing and round-robin ties, "b" with
// single-cycle strobes and write priority. Each drives a small SRAM model.
// Expected completions go into a per-instance queue; a monitor pops them as
// acks/valids appear and also checks strobe widths and turnaround gaps.

module tb_sram_access_arbiter;

  typedef struct packed {
    logic        is_wr;
    logic [19:0] addr;
    logic [15:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic preload = 1'b1;

  logic        wr_req_a = 1'b0, rd_req_a = 1'b0;
  logic [19:0] wr_addr_a = '0, rd_addr_a = '0;
  logic [15:0] wr_data_a = '0;
  logic        wr_ack_a, rd_valid_a, busy_a, dq_oe_a;
  logic [15:0] rd_data_a, sram_dq_a, sram_in_a;
  logic [19:0] sram_addr_a;
  logic        ce_n_a, oe_n_a, we_n_a, lb_n_a, ub_n_a;

  logic        wr_req_b = 1'b0, rd_req_b = 1'b0;
  logic [19:0] wr_addr_b = '0, rd_addr_b = '0;
  logic [15:0] wr_data_b = '0;
  logic        wr_ack_b, rd_valid_b, busy_b, dq_oe_b;
  logic [15:0] rd_data_b, sram_dq_b, sram_in_b;
  logic [19:0] sram_addr_b;
  logic        ce_n_b, oe_n_b, we_n_b, lb_n_b, ub_n_b;

  logic [15:0] mem_a [0:63];
  logic [15:0] mem_b [0:63];

  exp_t sb_a[$];
  exp_t sb_b[$];

  int n_compared = 0;
  int n_mismatched = 0;

  int we_run [2];
  int oe_run [2];
  int gap    [2];
  bit had_acc[2];
  bit gap_en [2];
  bit prev_oe_low[2];

  sram_access_arbiter #(
    .ADDR_W(20), .DATA_W(16), .WR_CYCLES(2), .RD_CYCLES(2), .PRIO_WR(0)
  ) dut_a (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_wr_req(wr_req_a), .i_wr_addr(wr_addr_a), .i_wr_data(wr_data_a),
    .o_wr_ack(wr_ack_a),
    .i_rd_req(rd_req_a), .i_rd_addr(rd_addr_a),
    .o_rd_data(rd_data_a), .o_rd_valid(rd_valid_a), .o_busy(busy_a),
    .o_sram_addr(sram_addr_a), .o_sram_dq(sram_dq_a), .o_sram_dq_oe(dq_oe_a),
    .i_sram_dq(sram_in_a),
    .o_sram_ce_n(ce_n_a), .o_sram_oe_n(oe_n_a), .o_sram_we_n(we_n_a),
    .o_sram_lb_n(lb_n_a), .o_sram_ub_n(ub_n_a)
  );

  sram_access_arbiter #(
    .ADDR_W(20), .DATA_W(16), .WR_CYCLES(1), .RD_CYCLES(1), .PRIO_WR(1)
  ) dut_b (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_wr_req(wr_req_b), .i_wr_addr(wr_addr_b), .i_wr_data(wr_data_b),
    .o_wr_ack(wr_ack_b),
    .i_rd_req(rd_req_b), .i_rd_addr(rd_addr_b),
    .o_rd_data(rd_data_b), .o_rd_valid(rd_valid_b), .o_busy(busy_b),
    .o_sram_addr(sram_addr_b), .o_sram_dq(sram_dq_b), .o_sram_dq_oe(dq_oe_b),
    .i_sram_dq(sram_in_b),
    .o_sram_ce_n(ce_n_b), .o_sram_oe_n(oe_n_b), .o_sram_we_n(we_n_b),
    .o_sram_lb_n(lb_n_b), .o_sram_ub_n(ub_n_b)
  );

  // Free-running system clock
  always #5 clk = ~clk;

  // SRAM model for instance a: preload, then write while CE and WE are low
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 64; i++) mem_a[i] <= 16'h0000;
      mem_a[5] <= 16'h1234;
    end else if (!ce_n_a && !we_n_a) begin
      mem_a[sram_addr_a[5:0]] <= sram_dq_a;
    end
  end

  // SRAM model for instance b
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 64; i++) mem_b[i] <= 16'h0000;
      mem_b[7] <= 16'h7E57;
    end else if (!ce_n_b && !we_n_b) begin
      mem_b[sram_addr_b[5:0]] <= sram_dq_b;
    end
  end

  assign sram_in_a = (!ce_n_a && !oe_n_a) ? mem_a[sram_addr_a[5:0]] : 16'h0000;
  assign sram_in_b = (!ce_n_b && !oe_n_b) ? mem_b[sram_addr_b[5:0]] : 16'h0000;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Queue an expected completion and raise the matching request
  task automatic apply_stimulus(input int id, input bit is_wr, input logic [19:0] addr,
                                input logic [15:0] data, input logic [15:0] exp_rd);
    exp_t e;
    e.is_wr = is_wr;
    e.addr  = addr;
    e.data  = is_wr ? data : exp_rd;
    if (id == 0) begin
      sb_a.push_back(e);
      if (is_wr) begin wr_addr_a = addr; wr_data_a = data; wr_req_a = 1'b1; end
      else begin rd_addr_a = addr; rd_req_a = 1'b1; end
    end else begin
      sb_b.push_back(e);
      if (is_wr) begin wr_addr_b = addr; wr_data_b = data; wr_req_b = 1'b1; end
      else begin rd_addr_b = addr; rd_req_b = 1'b1; end
    end
  endtask

  function automatic bit sig_now(input int id, input int which);
    case (which)
      0:       return (id == 0) ? wr_ack_a   : wr_ack_b;
      1:       return (id == 0) ? rd_valid_a : rd_valid_b;
      default: return (id == 0) ? !we_n_a    : !we_n_b;
    endcase
  endfunction

  // Wait at negedges for an event, bounded; timeout counts as a failure
  task automatic wait_sig(input int id, input int which, input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      seen = sig_now(id, which);
    end
    if (!seen) check(name, 32'd0, 32'd1);
  endtask

  // Reset-state comparison of one instance
  task automatic check_output(input string tag, input logic ce_n, oe_n, we_n, lb_n, ub_n,
                              input logic dq_oe, ack, valid, busy,
                              input logic [19:0] addr, input logic [15:0] dq, rdd);
    check({tag, "_strobes"}, {27'd0, ce_n, oe_n, we_n, lb_n, ub_n}, 32'h1F);
    check({tag, "_flags"}, {28'd0, dq_oe, ack, valid, busy}, 32'h0);
    check({tag, "_addr_dq"}, {addr[15:0], dq}, 32'h0);
    check({tag, "_rd_data"}, {16'd0, rdd}, 32'h0);
  endtask

  // One monitor step for an instance, sampled shortly after the clock edge
  task automatic mon_step(input int id, input int wr_cyc, input int rd_cyc, input logic rst,
                          input logic ce_n, oe_n, we_n, dq_oe, ack, valid,
                          input logic [19:0] addr, input logic [15:0] dq, rdd);
    exp_t e;
    if (!rst) begin
      we_run[id] = 0; oe_run[id] = 0; gap[id] = 0;
      had_acc[id] = 1'b0; prev_oe_low[id] = 1'b0;
      return;
    end
    if (!oe_n) check("dq_oe_during_read", {31'd0, dq_oe}, 32'd0);
    if (!we_n) we_run[id]++;
    else if (we_run[id] > 0) begin
      check("we_low_cycles", we_run[id], wr_cyc);
      we_run[id] = 0;
    end
    if (!oe_n) oe_run[id]++;
    else if (oe_run[id] > 0) begin
      check("oe_low_cycles", oe_run[id], rd_cyc);
      oe_run[id] = 0;
    end
    if (ce_n) gap[id]++;
    else begin
      if (gap[id] > 0) begin
        if (gap_en[id] && had_acc[id]) check("idle_gap", gap[id], 1);
        had_acc[id] = 1'b1;
      end
      gap[id] = 0;
    end
    if (ack) begin
      if ((id == 0 && sb_a.size() == 0) || (id == 1 && sb_b.size() == 0))
        check("unexpected_ack", 32'd1, 32'd0);
      else begin
        e = (id == 0) ? sb_a.pop_front() : sb_b.pop_front();
        check("ack_kind", {31'd0, e.is_wr}, 32'd1);
        check("ack_addr", {12'd0, addr}, {12'd0, e.addr});
        check("ack_dq", {16'd0, dq}, {16'd0, e.data});
        check("ack_in_last_we", we_run[id], wr_cyc);
        check("ack_dq_oe", {31'd0, dq_oe}, 32'd1);
      end
    end
    if (valid) begin
      if ((id == 0 && sb_a.size() == 0) || (id == 1 && sb_b.size() == 0))
        check("unexpected_valid", 32'd1, 32'd0);
      else begin
        e = (id == 0) ? sb_a.pop_front() : sb_b.pop_front();
        check("valid_kind", {31'd0, e.is_wr}, 32'd0);
        check("rd_data", {16'd0, rdd}, {16'd0, e.data});
        check("valid_after_read", {31'd0, prev_oe_low[id]}, 32'd1);
        check("valid_oe_released", {31'd0, oe_n}, 32'd1);
      end
    end
    prev_oe_low[id] = !oe_n;
  endtask

  // Monitor process: samples both instances 2 time units after each edge
  always @(posedge clk) begin
    #2;
    mon_step(0, 2, 2, rst_n, ce_n_a, oe_n_a, we_n_a, dq_oe_a, wr_ack_a, rd_valid_a,
             sram_addr_a, sram_dq_a, rd_data_a);
    mon_step(1, 1, 1, rst_n, ce_n_b, oe_n_b, we_n_b, dq_oe_b, wr_ack_b, rd_valid_b,
             sram_addr_b, sram_dq_b, rd_data_b);
  end

  // Watchdog
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed stimulus
  initial begin
    gap_en[0] = 1'b0;
    gap_en[1] = 1'b0;
    @(negedge clk);
    check_output("reset_a", ce_n_a, oe_n_a, we_n_a, lb_n_a, ub_n_a, dq_oe_a, wr_ack_a,
                 rd_valid_a, busy_a, sram_addr_a, sram_dq_a, rd_data_a);
    check_output("reset_b", ce_n_b, oe_n_b, we_n_b, lb_n_b, ub_n_b, dq_oe_b, wr_ack_b,
                 rd_valid_b, busy_b, sram_addr_b, sram_dq_b, rd_data_b);
    repeat (2) @(negedge clk);
    preload = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);

    // Reset in the middle of a write: strobes released, no ack ever follows
    $display("[TB] reset during write");
    wr_addr_a = 20'h00003; wr_data_a = 16'hDEAD; wr_req_a = 1'b1;
    wait_sig(0, 2, "we_low_before_reset");
    rst_n = 1'b0;
    @(negedge clk);
    wr_req_a = 1'b0;
    check("abort_strobes", {29'd0, ce_n_a, oe_n_a, we_n_a}, 32'h7);
    check("abort_dq_oe_ack", {30'd0, dq_oe_a, wr_ack_a}, 32'h0);
    check("abort_busy", {31'd0, busy_a}, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Single write
    $display("[TB] write 0xBEEF to 0x00010");
    apply_stimulus(0, 1'b1, 20'h00010, 16'hBEEF, 16'h0);
    @(negedge clk);
    check("wr_busy", {31'd0, busy_a}, 32'd1);
    check("wr_first_cycle_no_ack", {31'd0, wr_ack_a}, 32'd0);
    wait_sig(0, 0, "wr_ack_timeout");
    wr_req_a = 1'b0;
    repeat (3) @(negedge clk);

    // Single read of preloaded word
    $display("[TB] read 0x00005");
    apply_stimulus(0, 1'b0, 20'h00005, 16'h0, 16'h1234);
    wait_sig(0, 1, "rd_valid_timeout");
    rd_req_a = 1'b0;
    repeat (3) @(negedge clk);
    check("rd_data_held", {16'd0, rd_data_a}, 32'h1234);
    check("rd_valid_pulse", {31'd0, rd_valid_a}, 32'd0);

    // Round-robin with both requests held from reset
    $display("[TB] round robin from reset");
    rst_n = 1'b0;
    gap_en[0] = 1'b1;
    apply_stimulus(0, 1'b1, 20'h00021, 16'hA5A5, 16'h0);
    apply_stimulus(0, 1'b0, 20'h00021, 16'h0, 16'hA5A5);
    apply_stimulus(0, 1'b1, 20'h00021, 16'h5A5A, 16'h0);
    apply_stimulus(0, 1'b0, 20'h00021, 16'h0, 16'h5A5A);
    wr_data_a = 16'hA5A5;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wait_sig(0, 0, "rr_ack1_timeout");
    wr_data_a = 16'h5A5A;
    wait_sig(0, 1, "rr_valid1_timeout");
    wait_sig(0, 0, "rr_ack2_timeout");
    wr_req_a = 1'b0;
    wait_sig(0, 1, "rr_valid2_timeout");
    rd_req_a = 1'b0;
    repeat (3) @(negedge clk);
    gap_en[0] = 1'b0;
    check("rr_queue_drained", sb_a.size(), 0);

    // Write priority: ten back-to-back writes, the read waits
    $display("[TB] write priority");
    rd_addr_b = 20'h00030; rd_req_b = 1'b1;
    for (int k = 0; k < 10; k++) begin
      apply_stimulus(1, 1'b1, 20'h00030, 16'h1111, 16'h0);
      wait_sig(1, 0, "prio_ack_timeout");
    end
    wr_req_b = 1'b0;
    apply_stimulus(1, 1'b0, 20'h00030, 16'h0, 16'h1111);
    @(negedge clk);
    check("prio_idle_after_drop", {31'd0, oe_n_b}, 32'd1);
    @(negedge clk);
    check("prio_first_read_grant", {31'd0, oe_n_b}, 32'd0);
    wait_sig(1, 1, "prio_valid_timeout");
    rd_req_b = 1'b0;
    repeat (3) @(negedge clk);

    // Single-cycle strobes: write then two reads
    $display("[TB] single cycle accesses");
    apply_stimulus(1, 1'b1, 20'h00031, 16'hC3C3, 16'h0);
    wait_sig(1, 0, "sc_ack_timeout");
    wr_req_b = 1'b0;
    @(negedge clk);
    apply_stimulus(1, 1'b0, 20'h00007, 16'h0, 16'h7E57);
    wait_sig(1, 1, "sc_valid1_timeout");
    rd_req_b = 1'b0;
    @(negedge clk);
    apply_stimulus(1, 1'b0, 20'h00031, 16'h0, 16'hC3C3);
    wait_sig(1, 1, "sc_valid2_timeout");
    rd_req_b = 1'b0;
    repeat (3) @(negedge clk);
    check("sc_rd_data_held", {16'd0, rd_data_b}, 32'hC3C3);
    check("sc_queue_drained", sb_b.size(), 0);

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
